// File: rtl/bip_pkg.sv
// Shared definitions for the BIP memory responder: default widths,
// responder state encoding and the HALT opcode.
package bip_pkg;

    // Default word and address widths of the BIP CPU.
    localparam int BIP_DATA_W = 16;
    localparam int BIP_ADDR_W = 11;

    // Responder states. CLEAR is reachable only when the DM clear feature
    // is compiled in.
    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    // Opcode occupying the top five bits of an instruction word; all-zero is HALT.
    localparam logic [4:0] OP_HALT = 5'b00000;

endpackage

// File: rtl/bip_ram.sv
// Single-port RAM: synchronous write, asynchronous (combinational) read.
// Used for both program and data memory. Contents are never reset.
module bip_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: one word per cycle when enabled.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read port is combinational so the CPU sees data in the same cycle.
    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/bip_memory_responder.sv
// Memory-side responder for the BIP CPU. Owns program memory (filled through
// a valid/ready load port while the CPU is held in reset) and data memory
// (read/written by the CPU while running).
// Optional feature: define BIP_MEM_DM_CLEAR_EN to zero the whole data memory
// (one word per cycle) after reset and after every RELOAD, before loading.
module bip_memory_responder
    import bip_pkg::*;
#(
    parameter int DATA_W   = BIP_DATA_W,
    parameter int ADDR_W   = BIP_ADDR_W,
    parameter int PM_DEPTH = 2048,
    parameter int DM_DEPTH = 1024
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              LOAD_VALID,
    output logic              LOAD_READY,
    input  logic [DATA_W-1:0] LOAD_DATA,
    input  logic              LOAD_LAST,
    input  logic              RELOAD,
    output logic              CPU_RESET,
    input  logic [ADDR_W-1:0] ADDR_PM,
    output logic [DATA_W-1:0] INSTRUCTION,
    input  logic [ADDR_W-1:0] ADDR_DM,
    input  logic              RD,
    input  logic              WR,
    input  logic [DATA_W-1:0] ACC,
    output logic [DATA_W-1:0] DM_IN,
    output logic [ADDR_W:0]   PROG_LEN,
    output logic              ERR
);

    localparam int PM_AW = (PM_DEPTH > 1) ? $clog2(PM_DEPTH) : 1;
    localparam int DM_AW = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;

    typedef logic [ADDR_W:0] len_t;

    // Data addresses at or above this limit are out of range.
    localparam len_t DM_LIMIT = len_t'(DM_DEPTH);
    // Index of the last PM word; accepting it ends the load automatically.
    localparam logic [PM_AW-1:0] PM_LAST_IDX = PM_AW'(PM_DEPTH - 1);
    // Word returned for fetches beyond the loaded program.
    localparam logic [DATA_W-1:0] HALT_WORD = {OP_HALT, {(DATA_W - 5){1'b0}}};

`ifdef BIP_MEM_DM_CLEAR_EN
    localparam logic [DM_AW-1:0] DM_LAST_IDX = DM_AW'(DM_DEPTH - 1);
    // Reset and RELOAD first sweep data memory to zero.
    localparam logic [1:0] ENTRY_STATE = ST_CLEAR;
`else
    // Reset and RELOAD go straight to program loading; DM keeps its contents.
    localparam logic [1:0] ENTRY_STATE = ST_LOAD;
`endif

    // ------------------------------------------------------------------
    // State and pointers
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [PM_AW-1:0] r_load_ptr;
    len_t             r_prog_len;
    logic             r_err;
`ifdef BIP_MEM_DM_CLEAR_EN
    logic [DM_AW-1:0] r_clr_ptr;
`endif

    logic              w_in_load;
    logic              w_in_run;
    logic              w_load_fire;
    logic              w_load_done;
    logic              w_dm_in_range;
    logic              w_dm_oob;
    logic              w_fetch_valid;

    logic              w_pm_we;
    logic [PM_AW-1:0]  w_pm_addr;
    logic [DATA_W-1:0] w_pm_rdata;

    logic              w_dm_we;
    logic [DM_AW-1:0]  w_dm_addr;
    logic [DATA_W-1:0] w_dm_wdata;
    logic [DATA_W-1:0] w_dm_rdata;

    assign w_in_load = (r_state == ST_LOAD);
    assign w_in_run  = (r_state == ST_RUN);

    // A load word is accepted whenever the loader offers one during LOAD.
    assign w_load_fire = w_in_load & LOAD_VALID;
    // The program ends on an explicit LAST or when PM is full.
    assign w_load_done = w_load_fire & (LOAD_LAST | (r_load_ptr == PM_LAST_IDX));

    assign w_dm_in_range = ({1'b0, ADDR_DM} < DM_LIMIT);
    assign w_dm_oob      = w_in_run & (RD | WR) & ~w_dm_in_range;

    // Fetches past the loaded program (or outside RUN) read as HALT.
    assign w_fetch_valid = w_in_run & ({1'b0, ADDR_PM} < r_prog_len);

    // ------------------------------------------------------------------
    // Program memory: written by the loader, read by CPU fetches
    // ------------------------------------------------------------------
    assign w_pm_we   = w_load_fire;
    assign w_pm_addr = w_in_load ? r_load_ptr : ADDR_PM[PM_AW-1:0];

    bip_ram #(
        .DEPTH (PM_DEPTH),
        .WIDTH (DATA_W),
        .AW    (PM_AW)
    ) u_pm (
        .clk     (CLK),
        .i_we    (w_pm_we),
        .i_addr  (w_pm_addr),
        .i_wdata (LOAD_DATA),
        .o_rdata (w_pm_rdata)
    );

    // ------------------------------------------------------------------
    // Data memory: CPU read/write in RUN, zero sweep in CLEAR
    // ------------------------------------------------------------------
`ifdef BIP_MEM_DM_CLEAR_EN
    logic w_in_clear;
    assign w_in_clear = (r_state == ST_CLEAR);
    assign w_dm_we    = w_in_clear | (w_in_run & WR & w_dm_in_range);
    assign w_dm_addr  = w_in_clear ? r_clr_ptr : ADDR_DM[DM_AW-1:0];
    assign w_dm_wdata = w_in_clear ? '0 : ACC;
`else
    assign w_dm_we    = w_in_run & WR & w_dm_in_range;
    assign w_dm_addr  = ADDR_DM[DM_AW-1:0];
    assign w_dm_wdata = ACC;
`endif

    bip_ram #(
        .DEPTH (DM_DEPTH),
        .WIDTH (DATA_W),
        .AW    (DM_AW)
    ) u_dm (
        .clk     (CLK),
        .i_we    (w_dm_we),
        .i_addr  (w_dm_addr),
        .i_wdata (w_dm_wdata),
        .o_rdata (w_dm_rdata)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign LOAD_READY  = w_in_load;
    assign CPU_RESET   = ~w_in_run;
    assign INSTRUCTION = w_fetch_valid ? w_pm_rdata : HALT_WORD;
    // Read data reflects the pre-write contents when RD and WR coincide.
    assign DM_IN       = (w_in_run & RD & w_dm_in_range) ? w_dm_rdata : '0;
    assign PROG_LEN    = r_prog_len;
    assign ERR         = r_err;

    // Responder FSM: CLEAR (optional) -> LOAD -> RUN, RELOAD returns to the entry state.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= ENTRY_STATE;
            r_load_ptr <= '0;
            r_prog_len <= '0;
            r_err      <= 1'b0;
`ifdef BIP_MEM_DM_CLEAR_EN
            r_clr_ptr  <= '0;
`endif
        end else begin
            // Out-of-range data access is sticky until the next reset.
            if (w_dm_oob) begin
                r_err <= 1'b1;
            end

            case (r_state)
`ifdef BIP_MEM_DM_CLEAR_EN
                ST_CLEAR: begin
                    if (r_clr_ptr == DM_LAST_IDX) begin
                        r_state <= ST_LOAD;
                    end else begin
                        r_clr_ptr <= r_clr_ptr + DM_AW'(1);
                    end
                end
`endif
                ST_LOAD: begin
                    if (w_load_done) begin
                        r_prog_len <= len_t'(r_load_ptr) + len_t'(1);
                        r_load_ptr <= '0;
                        r_state    <= ST_RUN;
                    end else if (w_load_fire) begin
                        r_load_ptr <= r_load_ptr + PM_AW'(1);
                    end
                end
                ST_RUN: begin
                    if (RELOAD) begin
                        r_state    <= ENTRY_STATE;
                        r_load_ptr <= '0;
                        r_prog_len <= '0;
`ifdef BIP_MEM_DM_CLEAR_EN
                        r_clr_ptr  <= '0;
`endif
                    end
                end
                default: begin
                    r_state <= ENTRY_STATE;
                end
            endcase
        end
    end

endmodule
